// File: rtl/turn_sequencer_pkg.sv
// turn_pkg: shared types and helpers for the turn sequencer and the display
// logic that decodes cur_player.
//   turn_state_e  : lifecycle state, explicit 2-bit encodings
//   next_player() : modulo-n increment of a player index (n in 2..8)
package turn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } turn_state_e;

  // Player indices fit in 8 bits for any legal player count; callers cast
  // to their own width.
  function automatic logic [7:0] next_player(input logic [7:0] cur,
                                             input logic [7:0] n);
    logic [7:0] inc;
    inc = cur + 8'd1;
    return (inc >= n) ? 8'd0 : inc;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer: per-turn cycle counter used for auto-pass.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   run        : count this cycle (high while the game is in PLAY)
//   clear      : restart the count (turn change or game entry)
//   select     : a move arrived this cycle; suppresses expiry
//   expire     : counter sits at TIMEOUT_CYCLES-1 with no move this cycle
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  input  logic select,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= cnt + CW'(1);
  end

  assign expire = run && !select && (cnt == LAST);

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: N-player turn manager with an IDLE/PLAY/DONE lifecycle,
// move counting with board-full detection, and rotation of the starting
// player between games.
// Optional feature macro: TURN_TIMEOUT_EN (adds a per-turn auto-pass timer).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse, begin a game (from IDLE or DONE)
//   select      : pulse, validated move by cur_player
//   game_over   : win detected, end the game
//   cur_player  : player whose turn it is
//   turn_count  : moves accepted this game
//   playing     : high while in PLAY
//   board_full  : pulse when turn_count reaches MAX_TURNS
//   timed_out   : pulse on auto-pass (constant 0 without the macro)
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_TURNS      = 9,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  localparam int PW = ($clog2(NUM_PLAYERS) < 1) ? 1 : $clog2(NUM_PLAYERS),
  localparam int TW = $clog2(MAX_TURNS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          select,
  input  logic          game_over,
  output logic [PW-1:0] cur_player,
  output logic [TW-1:0] turn_count,
  output logic          playing,
  output logic          board_full,
  output logic          timed_out
);

  localparam logic [7:0]    NP    = 8'(NUM_PLAYERS);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_TURNS);

  turn_state_e   state, state_n;
  logic [PW-1:0] fp, fp_n, cur_n, adv_player;
  logic [TW-1:0] cnt_n;
  logic          bf_n, to_n, expire, tclear;

  assign adv_player = PW'(next_player(8'(cur_player), NP));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fp         <= '0;
      cur_player <= '0;
      turn_count <= '0;
      board_full <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state      <= state_n;
      fp         <= fp_n;
      cur_player <= cur_n;
      turn_count <= cnt_n;
      board_full <= bf_n;
      timed_out  <= to_n;
    end
  end

  // state is itself registered, so this decode changes with the state edge
  assign playing = (state == PLAY);

  always_comb begin
    state_n = state;
    fp_n    = fp;
    cur_n   = cur_player;
    cnt_n   = turn_count;
    bf_n    = 1'b0;
    to_n    = 1'b0;
    tclear  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = PLAY;
        cur_n   = fp;
        cnt_n   = '0;
        tclear  = 1'b1;
      end
      PLAY: begin
        if (game_over) begin
          state_n = DONE;            // a coincident select is dropped
        end else if (select) begin
          cur_n  = adv_player;
          cnt_n  = turn_count + TW'(1);
          tclear = 1'b1;
          if (cnt_n == MAX_T) begin
            state_n = DONE;
            bf_n    = 1'b1;
          end
        end else if (expire) begin
          cur_n  = adv_player;
          to_n   = 1'b1;
          tclear = 1'b1;
        end
      end
      DONE: if (start) begin
        fp_n    = PW'(next_player(8'(fp), NP));
        cur_n   = fp_n;
        cnt_n   = '0;
        state_n = PLAY;
        tclear  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef TURN_TIMEOUT_EN
  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (state == PLAY),
    .clear  (tclear),
    .select (select),
    .expire (expire)
  );
`else
  // No timer: expiry never happens; the clear strobe and the timeout
  // parameter have no consumer.
  logic unused_timer;
  assign unused_timer = tclear & (TIMEOUT_CYCLES >= 2);
  assign expire       = 1'b0;
`endif

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Parametrised turn manager for the DE1-SoC game designs. It generalises the two-player toggle to N players, a game lifecycle (idle, playing, done), a move counter with board-full detection, and rotation of the starting player between games. An optional per-turn timeout auto-passes a stalled player. It sits between the input debouncer/move validator and the board/display logic, which consume `cur_player`.

## Interface
- `NUM_PLAYERS`, default 2: number of players; legal range is 2..8.
- `MAX_TURNS`, default 9: number of accepted moves after which the game ends as board-full.
- `TIMEOUT_CYCLES`, default 250_000_000: clock cycles allowed per turn. Used only under `TURN_TIMEOUT_EN`. Must be ≥ 2.
- `PW` (localparam) = max(1, $clog2(NUM_PLAYERS)).
- `TW` (localparam) = $clog2(MAX_TURNS+1).

Ports:
- `clk`  in  1  system clock; the block uses a single clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a game.
- `select`  in  1  one-cycle pulse indicating a validated move by `cur_player`.
- `game_over`  in  1  level/pulse from win detection; ends the game.
- `cur_player`  out  PW  index of the player whose turn it is.
- `turn_count`  out  TW  number of moves accepted in this game.
- `playing`  out  1  high while in PLAY.
- `board_full`  out  1  one-cycle pulse when `turn_count` reaches `MAX_TURNS`.
- `timed_out`  out  1  one-cycle pulse on an auto-pass. Tied to 0 without the macro.

## Operation
- The FSM has three states: IDLE, PLAY, DONE.
- Reset puts the block in:
  - state IDLE;
  - `cur_player`=0, first-player register=0;
  - `turn_count`=0;
  - `playing`=0, `board_full`=0, `timed_out`=0.
- IDLE:
  - `start` → PLAY; `cur_player` ← first-player register; `turn_count` ← 0.
  - `select` and `game_over` are ignored.
- PLAY, with precedence evaluated in this order each cycle:
  1. `game_over` → DONE. A simultaneous `select` is ignored; `cur_player` and `turn_count` hold.
  2. `select` → `cur_player` ← (`cur_player`+1) mod `NUM_PLAYERS`, wrapping from `NUM_PLAYERS`-1 to 0. `turn_count` ← `turn_count`+1.
     - If the new `turn_count` equals `MAX_TURNS`: go to DONE and pulse `board_full` in the same cycle that the count updates.
  3. Timeout expiry (macro only) → advance `cur_player` as above; `turn_count` unchanged; pulse `timed_out`.
- `start` during PLAY is ignored.
- DONE:
  - Outputs hold.
  - `start` → rotate the first-player register ((fp+1) mod N), load `cur_player` with the new value, clear `turn_count`, and enter PLAY.
  - `select` and `game_over` are ignored.
- `reset` overrides everything in any state, including mid-game and when it coincides with `start`.

## Timing
- All outputs are registered. Each response appears on the `clk` edge that samples its input, so it is visible on the following cycle.
- `playing` = (state == PLAY), registered together with the state.
- `board_full` and `timed_out` are single-cycle pulses, never asserted together.
- Back-to-back `select` pulses on consecutive cycles each advance the player once.

## Configuration
- Macro `TURN_TIMEOUT_EN` defined:
  - A turn timer counts cycles while in PLAY.
  - The timer clears on entry to PLAY, on every player change, and on `reset`.
  - When the timer reaches `TIMEOUT_CYCLES`-1 with no `select` in that cycle, the auto-pass fires.
  - A `select` in the expiry cycle wins: no `timed_out` pulse and the timer clears.
  - The timer is frozen in IDLE and DONE.
- Macro not defined: no timer logic is built, `timed_out` is constant 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `turn_pkg` holds:
  - the `turn_state_e` enum {IDLE, PLAY, DONE} with explicit 2-bit encodings;
  - a `next_player(cur, n)` modulo-increment function, shared with the display logic.
- Sub-module `turn_timer`:
  - parameter `TIMEOUT_CYCLES`;
  - inputs `clk`, `reset`, `run`, `clear`, `select`;
  - output `expire`;
  - instantiated only under `TURN_TIMEOUT_EN`.

## Test plan
- Reset, then `start`, then three `select` pulses with `NUM_PLAYERS`=3 → `cur_player` sequence 0,1,2,0; `turn_count`=3; `playing`=1.
- With `MAX_TURNS`=9, nine `select` pulses → on the 9th, `turn_count`=9, `board_full` pulses once, next state DONE. A 10th `select` changes nothing.
- `game_over` and `select` asserted in the same cycle in PLAY → DONE; `cur_player` and `turn_count` unchanged.
- Two consecutive games (`start` from DONE) → first player 0 for game 1 and 1 for game 2. With N=3, game 4 starts at player 0 (wrap).
- Under `TURN_TIMEOUT_EN` with `TIMEOUT_CYCLES`=10:
  - idle PLAY for 10 cycles → `timed_out` pulses, `cur_player` advances, `turn_count` unchanged;
  - `select` in the expiry cycle → no pulse.
- `reset` asserted mid-game with `turn_count`=5 → next cycle state IDLE, all outputs 0, first-player register 0.
